rr_arbiter_16: RTL and testbench

//   16-requester round-robin arbiter sharing one resource between requesters.

---
 rtl/rr_arbiter_16_pkg.sv | 14 +
 rtl/rr_arbiter_16_dec.sv | 18 +
 rtl/rr_arbiter_16.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_16.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
// Provides requester count, index width and the FSM state encoding.
// Pure definitions: no logic, no latency, no flow control.
package rr_arbiter_16_pkg;

  localparam int ARB_N   = 16;
  localparam int ARB_IDW = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_16_dec.sv
// decoder_4X16: expands a 4-bit index into a one-hot 16-bit vector when enabled.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: in = index, en = enable (all-zero output when low), d = one-hot result.
module decoder_4X16
  import rr_arbiter_16_pkg::*;
(
  input  logic [ARB_IDW-1:0] in,
  input  logic               en,
  output logic [ARB_N-1:0]   d
);

  always_comb begin
    d = '0;
    if (en) d[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-requester round-robin arbiter with a bounded hold time per owner.
// Latency: gnt rises one cycle after req is first sampled; reset clears gnt asynchronously.
// Backpressure: requesters hold req until granted; en=0 blocks new grants only.
// Ports: clk, rst_n (async active-low), en, req[15:0] in;
//        gnt[15:0] one-hot, gnt_id[3:0] registered owner, gnt_valid registered out.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid
);

  arb_state_e         r_state;
  logic [ARB_IDW-1:0] r_ptr;
  logic [ARB_IDW-1:0] r_gnt_id;
  logic               r_gnt_valid;
  logic [CNT_W-1:0]   r_hold_cnt;

  arb_state_e         w_state_nxt;
  logic [ARB_IDW-1:0] w_ptr_nxt;
  logic [ARB_IDW-1:0] w_gnt_id_nxt;
  logic               w_gnt_valid_nxt;
  logic [CNT_W-1:0]   w_hold_cnt_nxt;

  logic               w_own_req;
  logic               w_timeout;
  logic               w_release;
  logic [ARB_IDW-1:0] w_ptr_rel;
  logic [ARB_N-1:0]   w_own_mask;
  logic [ARB_N-1:0]   w_req_excl;

  // First set bit of vec scanning ptr, ptr+1, ... wrapping mod 16.
  // Rotating right by ptr turns this into a plain lowest-bit search.
  function automatic logic [ARB_IDW-1:0] f_rr_pick(
    input logic [ARB_N-1:0]   i_vec,
    input logic [ARB_IDW-1:0] i_ptr
  );
    logic [2*ARB_N-1:0] l_dbl;
    logic [ARB_N-1:0]   l_rot;
    logic [ARB_IDW-1:0] l_off;
    l_dbl = {i_vec, i_vec} >> i_ptr;
    l_rot = l_dbl[ARB_N-1:0];
    l_off = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (l_rot[i]) l_off = ARB_IDW'(i);
    end
    return i_ptr + l_off;
  endfunction

  assign w_own_req  = req[r_gnt_id];
  assign w_timeout  = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
  // A dropped request wins over a simultaneous timeout.
  assign w_release  = !w_own_req || w_timeout;
  assign w_ptr_rel  = r_gnt_id + ARB_IDW'(1);
  assign w_own_mask = ARB_N'(1) << r_gnt_id;
  // Only a timed-out owner is excluded, so it yields to any other requester.
  assign w_req_excl = (w_timeout && w_own_req) ? (req & ~w_own_mask) : req;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_hold_cnt_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (en && |req) begin
          w_gnt_id_nxt    = f_rr_pick(req, r_ptr);
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = '0;
          w_state_nxt     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        if (w_release) begin
          w_ptr_nxt = w_ptr_rel;
          if (en && |w_req_excl) begin
            // Hand over in the same cycle: no idle gap on gnt_valid.
            w_gnt_id_nxt   = f_rr_pick(w_req_excl, w_ptr_rel);
            w_hold_cnt_nxt = '0;
          end else if (en && w_own_req) begin
            // Timed-out owner is the only requester left: give it a fresh window.
            w_hold_cnt_nxt = '0;
          end else begin
            w_gnt_valid_nxt = 1'b0;
            w_hold_cnt_nxt  = '0;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

  // Decoder is enabled by the registered valid, so reset clears gnt without a clock.
  decoder_4X16 u_dec (
    .in (r_gnt_id),
    .en (r_gnt_valid),
    .d  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] req;

  logic [15:0] gnt_w [3];
  logic [3:0]  id_w  [3];
  logic        vld_w [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Three instances share the same stimulus: default hold, short hold, single-cycle hold.
  rr_arbiter_16 #(.HOLD_MAX(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_valid(vld_w[0]));
  rr_arbiter_16 #(.HOLD_MAX(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_valid(vld_w[1]));
  rr_arbiter_16 #(.HOLD_MAX(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[2]), .gnt_id(id_w[2]), .gnt_valid(vld_w[2]));

  // Reference model: an owner, how many cycles it has been granted, and where the
  // next scan starts. Picks are a linear scan with modular index arithmetic.
  int hm      [3] = '{8, 2, 1};
  bit m_busy  [3];
  int m_owner [3];
  int m_held  [3];
  int m_next  [3];

  function automatic int m_pick(input logic [15:0] v, input int start);
    for (int k = 0; k < 16; k++) begin
      if (v[(start + k) % 16]) return (start + k) % 16;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_busy[d] = 0; m_owner[d] = 0; m_held[d] = 0; m_next[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        bit          own;
        bit          tmo;
        logic [15:0] cand;
        if (m_busy[d]) begin
          m_held[d] = m_held[d] + 1;
          own = req[m_owner[d]];
          tmo = (m_held[d] >= hm[d]);
          if (!own || tmo) begin
            m_next[d] = (m_owner[d] + 1) % 16;
            cand = req;
            if (own) cand[m_owner[d]] = 1'b0;
            if (en && cand != 16'h0) begin
              m_owner[d] = m_pick(cand, m_next[d]);
              m_held[d]  = 0;
            end else if (en && own) begin
              m_held[d] = 0;
            end else begin
              m_busy[d] = 0;
            end
          end
        end else if (en && req != 16'h0) begin
          m_owner[d] = m_pick(req, m_next[d]);
          m_busy[d]  = 1;
          m_held[d]  = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 16'h0; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 16'hFFFF; en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (gnt_w[d] !== 16'h0 || vld_w[d] !== 1'b0 || id_w[d] !== 4'h0) begin
          n_fail++;
          $display("FAIL reset dut%0d: gnt=%h vld=%b id=%0d, want gnt=0000 vld=0 id=0",
                   d, gnt_w[d], vld_w[d], id_w[d]);
        end
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 16'h0020;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_w[0] !== 16'h0020) begin
        n_fail++;
        $display("FAIL single_hold c%0d: gnt=%h, want 0020", c, gnt_w[0]);
      end
    end
    req = 16'h0000;
    @(negedge clk);
    n_tests++;
    if (gnt_w[0] !== 16'h0000 || vld_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: gnt=%h vld=%b, want 0000 0", gnt_w[0], vld_w[0]);
    end
    // Scan resumes at 6: bit 6 must win over bit 4.
    req = 16'h0050;
    @(negedge clk);
    n_tests++;
    if (gnt_w[0] !== 16'h0040 || id_w[0] !== 4'd6) begin
      n_fail++;
      $display("FAIL single_next_ptr: gnt=%h id=%0d, want 0040 id 6", gnt_w[0], id_w[0]);
    end
    req = 16'h0000;
  endtask

  task automatic test_rotate();
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      n_tests++;
      if (vld_w[1] !== 1'b1 || id_w[1] !== 4'((k / 2) % 16)) begin
        n_fail++;
        $display("FAIL rotate_hold2 k%0d: vld=%b id=%0d, want 1 id %0d",
                 k, vld_w[1], id_w[1], (k / 2) % 16);
      end
      n_tests++;
      if (vld_w[2] !== 1'b1 || id_w[2] !== 4'(k % 16)) begin
        n_fail++;
        $display("FAIL rotate_hold1 k%0d: vld=%b id=%0d, want 1 id %0d",
                 k, vld_w[2], id_w[2], k % 16);
      end
    end
    req = 16'h0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000;
    @(negedge clk);
    n_tests++;
    if (id_w[0] !== 4'd14 || vld_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_first: id=%0d vld=%b, want 14 1", id_w[0], vld_w[0]);
    end
    req = 16'h8001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (id_w[0] !== 4'd15 || vld_w[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_15 c%0d: id=%0d vld=%b, want 15 1", c, id_w[0], vld_w[0]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (id_w[0] !== 4'd0 || vld_w[0] !== 1'b1 || gnt_w[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_0: id=%0d vld=%b gnt=%h, want 0 1 0001", id_w[0], vld_w[0], gnt_w[0]);
    end
    req = 16'h0000;
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_w[0] !== 16'h0 || vld_w[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL en_block c%0d: gnt=%h vld=%b, want 0000 0", c, gnt_w[0], vld_w[0]);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_w[0] !== 16'h0100) begin
      n_fail++;
      $display("FAIL en_grant: gnt=%h, want 0100", gnt_w[0]);
    end
    // en falls mid-grant: the grant runs its full window, then no new grant.
    en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_w[0] !== 16'h0100) begin
        n_fail++;
        $display("FAIL en_fall_hold c%0d: gnt=%h, want 0100", c, gnt_w[0]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (gnt_w[0] !== 16'h0 || vld_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_fall_end: gnt=%h vld=%b, want 0000 0", gnt_w[0], vld_w[0]);
    end
    req = 16'h0000; en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 16'h0008;
    @(negedge clk);
    n_tests++;
    if (gnt_w[0] !== 16'h0008) begin
      n_fail++;
      $display("FAIL arst_pre: gnt=%h, want 0008", gnt_w[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt_w[0] !== 16'h0 || vld_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: gnt=%h vld=%b, want 0000 0", gnt_w[0], vld_w[0]);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 16'h0009;
    @(negedge clk);
    n_tests++;
    if (id_w[0] !== 4'd0 || gnt_w[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL arst_rescan: id=%0d gnt=%h, want 0 0001", id_w[0], gnt_w[0]);
    end
    req = 16'h0000;
  endtask

  task automatic test_random();
    logic [15:0] exp_g;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: req = 16'($urandom);
        1: req = 16'(1 << $urandom_range(0, 15));
        2: req = req;
        default: req = req & 16'($urandom);
      endcase
      en = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        exp_g = 16'h0;
        if (m_busy[d]) exp_g[m_owner[d]] = 1'b1;
        n_tests++;
        if (gnt_w[d] !== exp_g || vld_w[d] !== m_busy[d] ||
            (m_busy[d] && id_w[d] !== 4'(m_owner[d]))) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: gnt=%h vld=%b id=%0d, want gnt=%h vld=%b id=%0d",
                   d, i, gnt_w[d], vld_w[d], id_w[d], exp_g, m_busy[d], m_owner[d]);
        end
      end
    end
    req = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b1; req = 16'h0; en = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_single_hold();
    test_rotate();
    test_wrap();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
